// File: rtl/rf_pkg.sv
// Shared widths and record types for the register-file write arbiter.
package rf_pkg;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;
    localparam int NREGS  = 2 ** SEL_W;

    // Default-width view of one holding slot: full flag, destination, payload.
    typedef struct packed {
        logic              full;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } slot_t;

    typedef enum logic {
        WIN_SLOT0 = 1'b0,
        WIN_SLOT1 = 1'b1
    } win_e;
endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding slot for a writeback requester; refills in the same
// cycle its current entry is granted.
module rf_wr_slot #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int SEL_W  = rf_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              grant,
    output logic              load,
    output logic              full,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] data
);
    assign ready = !full || grant;
    assign load  = valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

    // Payload is not reset: it is only observed while full is set.
    always_ff @(posedge clk) begin
        if (load) begin
            sel  <= sel_in;
            data <= data_in;
        end
    end
endmodule

// File: rtl/rf_wr_arb.sv
// Two-requester register-file write arbiter: per-requester holding slots,
// age/round-robin arbitration and same-register collision flag.
module rf_wr_arb #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int SEL_W  = rf_pkg::SEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [SEL_W-1:0]     req0_sel,
    input  logic [DATA_W-1:0]    req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [SEL_W-1:0]     req1_sel,
    input  logic [DATA_W-1:0]    req1_data,
    output logic                 wr_en,
    output logic [SEL_W-1:0]     wr_sel,
    output logic [DATA_W-1:0]    wr_data,
    output logic [2**SEL_W-1:0]  pending,
    output logic                 err
);
    import rf_pkg::*;

    logic              full0, full1, load0, load1, grant0, grant1;
    logic [SEL_W-1:0]  sel0, sel1;
    logic [DATA_W-1:0] data0, data1;
    logic              age, tie, rr, coll;
    win_e              win;

    rf_wr_slot #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_slot0 (
        .clk(clk), .rst(rst), .valid(req0_valid), .ready(req0_ready),
        .sel_in(req0_sel), .data_in(req0_data), .grant(grant0), .load(load0),
        .full(full0), .sel(sel0), .data(data0)
    );

    rf_wr_slot #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_slot1 (
        .clk(clk), .rst(rst), .valid(req1_valid), .ready(req1_ready),
        .sel_in(req1_sel), .data_in(req1_data), .grant(grant1), .load(load1),
        .full(full1), .sel(sel1), .data(data1)
    );

    // Older slot wins; a same-edge pair falls to rr, except a collision,
    // which always drains slot 0 first so requester 1 lands last.
    always_comb begin
        win = WIN_SLOT0;
        if (full0 && full1) begin
            if (coll)
                win = WIN_SLOT0;
            else if (tie)
                win = rr ? WIN_SLOT1 : WIN_SLOT0;
            else
                win = age ? WIN_SLOT1 : WIN_SLOT0;
        end else if (full1) begin
            win = WIN_SLOT1;
        end
    end

    assign grant0 = full0 && (win == WIN_SLOT0);
    assign grant1 = full1 && (win == WIN_SLOT1);
    assign wr_en  = full0 || full1;
    assign err    = coll;

    always_comb begin
        wr_sel  = '0;
        wr_data = '0;
        if (grant0) begin
            wr_sel  = sel0;
            wr_data = data0;
        end else if (grant1) begin
            wr_sel  = sel1;
            wr_data = data1;
        end
    end

    always_comb begin
        pending = '0;
        if (full0) pending[sel0] = 1'b1;
        if (full1) pending[sel1] = 1'b1;
    end

    // age=1 means slot 1 holds the older entry; only meaningful with both full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age  <= 1'b0;
            tie  <= 1'b0;
            rr   <= 1'b0;
            coll <= 1'b0;
        end else begin
            tie  <= load0 && load1;
            coll <= load0 && load1 && (req0_sel == req1_sel);
            if (load0 && !load1)
                age <= 1'b1;
            else if (load1 && !load0)
                age <= 1'b0;
            if (full0 && full1)
                rr <= !rr;
        end
    end
endmodule
